mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory-access stage directly downstream of the execute stage, which itself consumes the op-read stage latch outputs.
- Takes the ALU result, store data, rd, funct3 and acc_size of one instruction, and performs loads/stores on a req/ack data bus.
- Aligns and extends load data, then registers the writeback bundle for the writeback stage.
- Asserts busy so pipeline control holds the upstream latch while a bus access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: ACCESS cycles without ack before a bus error is reported; 0 disables the timeout.
- CNT_W, 8: width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2**CNT_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input bundle holds a real instruction (0 = bubble).
- alu_result  in  32  effective address for mem ops; result value otherwise.
- rs2_data  in  32  store data.
- rd  in  5  destination register.
- funct3  in  3  bit 2 = unsigned load (LBU/LHU).
- acc_size  in  2  00 byte, 01 half, 10 word; 11 reserved, treated as word.
- is_load, is_store, reg_write  in  1 each  decoded control flags; is_load and is_store are never both 1.
- busy  out  1  combinational; upstream must hold its inputs while 1.
- dmem_req  out  1  bus request, registered.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_rdata  in  32  read data, valid with ack.
- dmem_ack  in  1  completes the request in the same cycle.
- wb_valid  out  1  writeback bundle valid.
- wb_we  out  1  register-file write enable.
- wb_rd  out  5  destination register.
- wb_data  out  32  result or extended load data.
- misalign_exc  out  1  one-cycle pulse on a misaligned access.
- bus_err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset: the rst_n-low edge forces state IDLE, counter 0, and every registered output to 0, including during ACCESS. The request is dropped with no bus_err.
- States: IDLE and ACCESS.
- IDLE, in_valid with neither is_load nor is_store:
  - Next edge: wb_valid=1, wb_we=reg_write, wb_rd=rd, wb_data=alu_result.
  - busy=0. Latency is 1 cycle.
- IDLE, in_valid=0: wb_valid=0 and wb_we=0 next edge (bubble).
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0.
  - No bus access.
  - Next edge: misalign_exc=1, wb_valid=1, wb_we=0. busy=0.
- IDLE, aligned mem op:
  - busy=1.
  - Next edge: latch dmem_addr, dmem_we=is_store, dmem_wdata, dmem_be, rd, funct3, acc_size, addr[1:0]; set dmem_req=1 and counter 0; enter ACCESS.
  - wb_valid=0 on that edge.
- Store lanes:
  - byte: wdata={4{rs2[7:0]}}, be=1<<addr[1:0].
  - half: wdata={2{rs2[15:0]}}, be=0011 if addr[1]=0, else 1100.
  - word: wdata=rs2, be=1111.
- Load lanes: dmem_be as for stores of the same size (informational).
- ACCESS:
  - busy = !(dmem_ack | timeout_hit), where timeout_hit = (TIMEOUT_CYCLES!=0) && (counter==TIMEOUT_CYCLES-1).
  - dmem_ack=1: next edge dmem_req=0 and state IDLE.
    - Load: wb_valid=1, wb_we=latched reg_write, wb_data=extracted data.
    - Store: wb_valid=1, wb_we=0.
  - dmem_ack=1 takes priority over timeout_hit in the same cycle.
  - timeout_hit without ack: next edge dmem_req=0, bus_err=1, wb_valid=1, wb_we=0, state IDLE.
  - Otherwise: counter+1, wb_valid=0.
  - Inputs are ignored in ACCESS; upstream is held.
- Load extraction:
  - Select byte addr[1:0] or half addr[1] from dmem_rdata.
  - Zero-extend if funct3[2]=1, else sign-extend.
  - Word is passed unchanged.
- Latency:
  - Load with ack in the first ACCESS cycle: 2 cycles from acceptance to wb_valid.
  - Each ack wait cycle adds 1.
- Pulses: misalign_exc and bus_err are high for exactly one cycle.
- wb_rd=0 with wb_we=1 is allowed; the register file ignores x0.

Decomposition:
- Shared package (pipeline_pkg):
  - ACC_BYTE/ACC_HALF/ACC_WORD encodings.
  - State encoding for IDLE/ACCESS.
  - FUNCT3_UNSIGNED_BIT index.
- One combinational sub-module, mem_load_extract: inputs rdata, addr_lo[1:0], acc_size, unsigned; output 32-bit extended data. It is reused by a future cache path.
- Store lane/be generation stays inline.

Test Plan:
- ALU op rd=5, alu_result=0x1234, reg_write=1 -> next cycle wb_valid=1, wb_we=1, wb_rd=5, wb_data=0x1234, busy=0 throughout.
- LB at 0x1003, dmem_rdata=0x80FFFFFF, ack in first ACCESS cycle -> dmem_addr=0x1000, wb_data=0xFFFFFF80; with funct3[2]=1 (LBU) -> 0x00000080; wb_valid 2 cycles after acceptance.
- SH rs2=0xABCD1234 at 0x2002, ack after 3 wait cycles -> dmem_we=1, be=1100, wdata=0x12341234; busy high 4 cycles; wb_we=0.
- LW at 0x3001 -> no dmem_req; misalign_exc pulses 1 cycle; wb_valid=1, wb_we=0.
- TIMEOUT_CYCLES=4, ack never arrives -> dmem_req high exactly 4 cycles; bus_err pulse; state IDLE; next ALU op completes normally.
- rst_n low for 1 cycle mid-ACCESS -> next edge dmem_req=0, wb_valid=0, no bus_err; a late ack is ignored.

Source files
------------

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_pkg
// Brief    : Shared encodings for the memory-access stage and its helpers.
// Revision : 1.0  initial release
// ============================================================================
package pipeline_pkg;

    localparam logic [1:0] ACC_BYTE = 2'b00;
    localparam logic [1:0] ACC_HALF = 2'b01;
    localparam logic [1:0] ACC_WORD = 2'b10;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    localparam int FUNCT3_UNSIGNED_BIT = 2;

endpackage
`default_nettype wire

// File: rtl/mem_load_extract.sv
`default_nettype none
// ============================================================================
// Module   : mem_load_extract
// Brief    : Selects the addressed byte/half of a bus word and extends it.
// Revision : 1.0  initial release
// ============================================================================
module mem_load_extract
    import pipeline_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  acc_size,
    input  logic        unsigned_ld,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        half_sel = 16'h0000;
        data     = rdata;
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (acc_size)
            ACC_BYTE: data = {{24{byte_sel[7] & ~unsigned_ld}}, byte_sel};
            ACC_HALF: data = {{16{half_sel[15] & ~unsigned_ld}}, half_sel};
            default:  data = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Brief    : Load/store stage on a req/ack bus with registered writeback.
// Revision : 1.0  initial release
// ============================================================================
module mem_access_stage
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic [1:0]  acc_size,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        reg_write,
    output logic        busy,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign_exc,
    output logic        bus_err
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       lat_rd;
    logic [2:0]       lat_funct3;
    logic [1:0]       lat_acc_size;
    logic [1:0]       lat_addr_lo;
    logic             lat_reg_write;

    logic             mem_op;
    logic             misaligned;
    logic             timeout_hit;
    logic [31:0]      st_wdata;
    logic [3:0]       st_be;
    logic [31:0]      ld_data;

    assign mem_op      = is_load | is_store;
    // Reserved size 11 behaves as a word, so bit 1 alone identifies word access.
    assign misaligned  = ((acc_size == ACC_HALF) && alu_result[0]) ||
                         (acc_size[1] && (alu_result[1:0] != 2'b00));
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TIMEOUT_LAST);

    always_comb begin
        busy = 1'b0;
        if (state == ST_ACCESS)
            busy = !(dmem_ack | timeout_hit);
        else
            busy = in_valid & mem_op & ~misaligned;
    end

    always_comb begin
        st_wdata = rs2_data;
        st_be    = 4'b1111;
        case (acc_size)
            ACC_BYTE: begin
                st_wdata = {4{rs2_data[7:0]}};
                st_be    = 4'b0001 << alu_result[1:0];
            end
            ACC_HALF: begin
                st_wdata = {2{rs2_data[15:0]}};
                st_be    = alu_result[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = rs2_data;
                st_be    = 4'b1111;
            end
        endcase
    end

    mem_load_extract u_extract (
        .rdata       (dmem_rdata),
        .addr_lo     (lat_addr_lo),
        .acc_size    (lat_acc_size),
        .unsigned_ld (lat_funct3[FUNCT3_UNSIGNED_BIT]),
        .data        (ld_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= 32'h0;
            dmem_wdata    <= 32'h0;
            dmem_be       <= 4'h0;
            lat_rd        <= 5'h0;
            lat_funct3    <= 3'h0;
            lat_acc_size  <= 2'h0;
            lat_addr_lo   <= 2'h0;
            lat_reg_write <= 1'b0;
            wb_valid      <= 1'b0;
            wb_we         <= 1'b0;
            wb_rd         <= 5'h0;
            wb_data       <= 32'h0;
            misalign_exc  <= 1'b0;
            bus_err       <= 1'b0;
        end else begin
            misalign_exc <= 1'b0;
            bus_err      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!in_valid) begin
                        wb_valid <= 1'b0;
                        wb_we    <= 1'b0;
                    end else if (!mem_op) begin
                        wb_valid <= 1'b1;
                        wb_we    <= reg_write;
                        wb_rd    <= rd;
                        wb_data  <= alu_result;
                    end else if (misaligned) begin
                        misalign_exc <= 1'b1;
                        wb_valid     <= 1'b1;
                        wb_we        <= 1'b0;
                        wb_rd        <= rd;
                        wb_data      <= alu_result;
                    end else begin
                        state         <= ST_ACCESS;
                        cnt           <= '0;
                        dmem_req      <= 1'b1;
                        dmem_we       <= is_store;
                        dmem_addr     <= {alu_result[31:2], 2'b00};
                        dmem_wdata    <= st_wdata;
                        dmem_be       <= st_be;
                        lat_rd        <= rd;
                        lat_funct3    <= funct3;
                        lat_acc_size  <= acc_size;
                        lat_addr_lo   <= alu_result[1:0];
                        lat_reg_write <= reg_write;
                        wb_valid      <= 1'b0;
                        wb_we         <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    if (dmem_ack) begin
                        state    <= ST_IDLE;
                        dmem_req <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_rd    <= lat_rd;
                        // dmem_we still holds the store flag of the access in flight.
                        wb_we    <= dmem_we ? 1'b0 : lat_reg_write;
                        if (!dmem_we)
                            wb_data <= ld_data;
                    end else if (timeout_hit) begin
                        state    <= ST_IDLE;
                        dmem_req <= 1'b0;
                        bus_err  <= 1'b1;
                        wb_valid <= 1'b1;
                        wb_we    <= 1'b0;
                        wb_rd    <= lat_rd;
                    end else begin
                        cnt      <= cnt + 1'b1;
                        wb_valid <= 1'b0;
                        wb_we    <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Brief    : Directed self-checking bench for mem_access_stage.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [1:0]  acc_size;
    logic        is_load;
    logic        is_store;
    logic        reg_write;
    logic        busy;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign_exc;
    logic        bus_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .alu_result   (alu_result),
        .rs2_data     (rs2_data),
        .rd           (rd),
        .funct3       (funct3),
        .acc_size     (acc_size),
        .is_load      (is_load),
        .is_store     (is_store),
        .reg_write    (reg_write),
        .busy         (busy),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_be      (dmem_be),
        .dmem_rdata   (dmem_rdata),
        .dmem_ack     (dmem_ack),
        .wb_valid     (wb_valid),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .misalign_exc (misalign_exc),
        .bus_err      (bus_err)
    );

    // Inputs change 1 time unit after the rising edge; outputs are read 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; reg_write = 1'b0;
        alu_result = 32'h0; rs2_data = 32'h0; rd = 5'd0; funct3 = 3'd0;
        acc_size = 2'b00; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick(); tick();
        total_cnt++;
        if (wb_valid !== 1'b0 || dmem_req !== 1'b0 || bus_err !== 1'b0 || misalign_exc !== 1'b0)
            $display("FAIL reset_outputs: wb_valid=%b dmem_req=%b bus_err=%b misalign=%b, want all 0",
                     wb_valid, dmem_req, bus_err, misalign_exc);
        else pass_cnt++;
        #1;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
        else pass_cnt++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        in_valid = 1'b1; rd = 5'd5; alu_result = 32'h1234; reg_write = 1'b1;
        #1;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL alu_busy: got %b want 0", busy);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (wb_valid !== 1'b1 || wb_we !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'h1234)
            $display("FAIL alu_wb: valid=%b we=%b rd=%0d data=%h want 1 1 5 00001234",
                     wb_valid, wb_we, wb_rd, wb_data);
        else pass_cnt++;
        idle_inputs();
        tick();
        total_cnt++;
        if (wb_valid !== 1'b0 || wb_we !== 1'b0)
            $display("FAIL bubble: valid=%b we=%b want 0 0", wb_valid, wb_we);
        else pass_cnt++;
    endtask

    task automatic test_load(input logic [31:0] addr, input logic [1:0] size,
                             input logic [2:0] f3, input logic [31:0] rdata,
                             input logic [3:0] exp_be, input logic [31:0] exp_data);
        in_valid = 1'b1; is_load = 1'b1; reg_write = 1'b1; rd = 5'd7;
        alu_result = addr; acc_size = size; funct3 = f3;
        #1;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL load_busy_accept: got %b want 1", busy);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== {addr[31:2], 2'b00} ||
            dmem_be !== exp_be || wb_valid !== 1'b0)
            $display("FAIL load_req: req=%b we=%b addr=%h be=%b wbv=%b want 1 0 %h %b 0",
                     dmem_req, dmem_we, dmem_addr, dmem_be, wb_valid, {addr[31:2], 2'b00}, exp_be);
        else pass_cnt++;
        dmem_ack = 1'b1; dmem_rdata = rdata;
        #1;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL load_busy_ack: got %b want 0", busy);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (dmem_req !== 1'b0 || wb_valid !== 1'b1 || wb_we !== 1'b1 || wb_rd !== 5'd7 ||
            wb_data !== exp_data)
            $display("FAIL load_wb: req=%b valid=%b we=%b rd=%0d data=%h want 0 1 1 7 %h",
                     dmem_req, wb_valid, wb_we, wb_rd, wb_data, exp_data);
        else pass_cnt++;
        idle_inputs();
        tick();
    endtask

    task automatic test_store_wait();
        int busy_hi = 0;
        in_valid = 1'b1; is_store = 1'b1; rs2_data = 32'hABCD1234; alu_result = 32'h2002;
        acc_size = 2'b01; rd = 5'd9; reg_write = 1'b0;
        #1; if (busy) busy_hi++;
        tick();
        total_cnt++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_be !== 4'b1100 ||
            dmem_wdata !== 32'h12341234 || dmem_addr !== 32'h2000)
            $display("FAIL store_req: req=%b we=%b be=%b wdata=%h addr=%h want 1 1 1100 12341234 00002000",
                     dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            #1; if (busy) busy_hi++;
            tick();
        end
        dmem_ack = 1'b1;
        #1; if (busy) busy_hi++;
        total_cnt++;
        if (busy_hi !== 4) $display("FAIL store_busy_cycles: got %0d want 4", busy_hi);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (wb_valid !== 1'b1 || wb_we !== 1'b0 || dmem_req !== 1'b0)
            $display("FAIL store_wb: valid=%b we=%b req=%b want 1 0 0", wb_valid, wb_we, dmem_req);
        else pass_cnt++;
        idle_inputs();
        tick();
    endtask

    task automatic test_misalign();
        in_valid = 1'b1; is_load = 1'b1; reg_write = 1'b1; alu_result = 32'h3001;
        acc_size = 2'b10; rd = 5'd3;
        #1;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL misalign_busy: got %b want 0", busy);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (misalign_exc !== 1'b1 || wb_valid !== 1'b1 || wb_we !== 1'b0 || dmem_req !== 1'b0)
            $display("FAIL misalign_wb: exc=%b valid=%b we=%b req=%b want 1 1 0 0",
                     misalign_exc, wb_valid, wb_we, dmem_req);
        else pass_cnt++;
        idle_inputs();
        tick();
        total_cnt++;
        if (misalign_exc !== 1'b0 || dmem_req !== 1'b0)
            $display("FAIL misalign_pulse: exc=%b req=%b want 0 0", misalign_exc, dmem_req);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int n = 0;
        in_valid = 1'b1; is_load = 1'b1; reg_write = 1'b1; alu_result = 32'h4000;
        acc_size = 2'b10; rd = 5'd4;
        tick();
        while (dmem_req && n < 20) begin
            n++;
            tick();
        end
        total_cnt++;
        if (n !== 4) $display("FAIL timeout_req_cycles: got %0d want 4", n);
        else pass_cnt++;
        total_cnt++;
        if (bus_err !== 1'b1 || wb_valid !== 1'b1 || wb_we !== 1'b0)
            $display("FAIL timeout_err: bus_err=%b valid=%b we=%b want 1 1 0", bus_err, wb_valid, wb_we);
        else pass_cnt++;
        idle_inputs();
        in_valid = 1'b1; rd = 5'd6; alu_result = 32'h55; reg_write = 1'b1;
        #1;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL timeout_idle_busy: got %b want 0", busy);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus_err !== 1'b0 || wb_valid !== 1'b1 || wb_we !== 1'b1 || wb_rd !== 5'd6 ||
            wb_data !== 32'h55)
            $display("FAIL timeout_next_alu: err=%b valid=%b we=%b rd=%0d data=%h want 0 1 1 6 00000055",
                     bus_err, wb_valid, wb_we, wb_rd, wb_data);
        else pass_cnt++;
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_access();
        in_valid = 1'b1; is_load = 1'b1; reg_write = 1'b1; alu_result = 32'h5000;
        acc_size = 2'b00; rd = 5'd8;
        tick();
        total_cnt++;
        if (dmem_req !== 1'b1) $display("FAIL rst_mid_req: got %b want 1", dmem_req);
        else pass_cnt++;
        idle_inputs();
        tick();
        rst_n = 1'b0;
        tick();
        total_cnt++;
        if (dmem_req !== 1'b0 || wb_valid !== 1'b0 || bus_err !== 1'b0)
            $display("FAIL rst_mid_clear: req=%b valid=%b err=%b want 0 0 0", dmem_req, wb_valid, bus_err);
        else pass_cnt++;
        rst_n = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
        tick();
        total_cnt++;
        if (wb_valid !== 1'b0 || dmem_req !== 1'b0 || wb_we !== 1'b0)
            $display("FAIL rst_late_ack: valid=%b req=%b we=%b want 0 0 0", wb_valid, dmem_req, wb_we);
        else pass_cnt++;
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load(32'h1003, 2'b00, 3'b000, 32'h80FFFFFF, 4'b1000, 32'hFFFFFF80);
        test_load(32'h1003, 2'b00, 3'b100, 32'h80FFFFFF, 4'b1000, 32'h00000080);
        test_load(32'h1002, 2'b01, 3'b001, 32'h80FFFFFF, 4'b1100, 32'hFFFF80FF);
        test_load(32'h1001, 2'b00, 3'b000, 32'h00007F00, 4'b0010, 32'h0000007F);
        test_store_wait();
        test_misalign();
        test_timeout();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
